// File: rtl/imem_arbiter_if.sv
// imem_arbiter_if: request/grant, response and memory-port signals between
// the instruction memory arbiter, its two requesters and the memory.
interface imem_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_valid;
  logic [31:0] if_inst;
  logic        ld_req;
  logic        ld_we;
  logic [31:0] ld_addr;
  logic [31:0] ld_wdata;
  logic        ld_gnt;
  logic        ld_rvalid;
  logic [31:0] ld_rdata;
  logic        ld_err;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic [1:0]  last_owner;
  modport slave (
    input  if_req, if_addr, ld_req, ld_we, ld_addr, ld_wdata, mem_rdata,
    output if_gnt, if_valid, if_inst, ld_gnt, ld_rvalid, ld_rdata, ld_err,
           mem_addr, mem_we, mem_wdata, last_owner
  );
  modport master (
    output if_req, if_addr, ld_req, ld_we, ld_addr, ld_wdata, mem_rdata,
    input  if_gnt, if_valid, if_inst, ld_gnt, ld_rvalid, ld_rdata, ld_err,
           mem_addr, mem_we, mem_wdata, last_owner
  );
endinterface

// File: rtl/imem_arbiter.sv
// imem_arbiter: single-port instruction memory arbiter, loader-priority with a
// bounded burst so fetch is served at least once every BURST_MAX+1 cycles.
module imem_arbiter #(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          BURST_MAX   = 4,
  parameter logic [31:0] NOP_INST    = 32'h00000013
) (
  input logic           clk,
  input logic           rst_n,
  imem_arbiter_if.slave bus
);
  localparam int              BW    = $clog2(BURST_MAX + 1);
  localparam logic [BW-1:0]   BMAX  = BW'(BURST_MAX);
  localparam logic [29:0]     DEPTH = 30'(DEPTH_WORDS);
  typedef enum logic [1:0] {IDLE, FETCH, LOAD} owner_e;
  owner_e        owner_q, owner_d;
  logic [BW-1:0] burst_q, burst_d;
  logic          if_valid_q, ld_rvalid_q, ld_err_q;
  logic [31:0]   if_inst_q, ld_rdata_q;
  logic          ld_gnt, if_gnt, ld_bad, if_oor;
  assign ld_bad = (bus.ld_addr[1:0] != 2'b00) | (bus.ld_addr[31:2] >= DEPTH);
  assign if_oor = bus.if_addr[31:2] >= DEPTH;
  // Grants are held off while in reset so nothing reaches memory mid-reset.
  assign ld_gnt = rst_n & bus.ld_req & ~(bus.if_req & (burst_q == BMAX));
  assign if_gnt = rst_n & bus.if_req & ~ld_gnt;
  assign bus.ld_gnt     = ld_gnt;
  assign bus.if_gnt     = if_gnt;
  assign bus.mem_addr   = ld_gnt ? bus.ld_addr : if_gnt ? bus.if_addr : 32'h0;
  assign bus.mem_we     = ld_gnt & bus.ld_we & ~ld_bad;
  assign bus.mem_wdata  = bus.ld_wdata;
  assign bus.if_valid   = if_valid_q;
  assign bus.if_inst    = if_inst_q;
  assign bus.ld_rvalid  = ld_rvalid_q;
  assign bus.ld_rdata   = ld_rdata_q;
  assign bus.ld_err     = ld_err_q;
  assign bus.last_owner = owner_q;
  always_comb begin
    owner_d = ld_gnt ? LOAD : if_gnt ? FETCH : IDLE;
    burst_d = (!bus.if_req || if_gnt) ? '0 :
              (ld_gnt && burst_q != BMAX) ? burst_q + BW'(1) : burst_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q     <= IDLE;
      burst_q     <= '0;
      if_valid_q  <= 1'b0;
      ld_rvalid_q <= 1'b0;
      ld_err_q    <= 1'b0;
      if_inst_q   <= 32'h0;
      ld_rdata_q  <= 32'h0;
    end else begin
      owner_q     <= owner_d;
      burst_q     <= burst_d;
      if_valid_q  <= if_gnt;
      ld_rvalid_q <= ld_gnt & ~bus.ld_we & ~ld_bad;
      ld_err_q    <= ld_gnt & ld_bad;
      if (if_gnt) if_inst_q <= if_oor ? NOP_INST : bus.mem_rdata;
      if (ld_gnt & ~bus.ld_we & ~ld_bad) ld_rdata_q <= bus.mem_rdata;
    end
  end
endmodule

// File: tb/tb_imem_arbiter.sv
// tb_imem_arbiter: directed vectors against a behavioural 1024-word memory.
module tb_imem_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int errors = 0;
  int checks = 0;
  logic [31:0] mem [0:1023];
  imem_arbiter_if bus ();
  imem_arbiter dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) if (bus.mem_we) mem[bus.mem_addr[11:2]] <= bus.mem_wdata;
  assign bus.mem_rdata = mem[bus.mem_addr[11:2]];
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic idle_all();
    bus.if_req = 0; bus.if_addr = 0; bus.ld_req = 0; bus.ld_we = 0;
    bus.ld_addr = 0; bus.ld_wdata = 0;
  endtask
  task automatic ld(input logic we, input logic [31:0] a, input logic [31:0] d);
    bus.ld_req = 1; bus.ld_we = we; bus.ld_addr = a; bus.ld_wdata = d;
  endtask
  task automatic post();
    @(posedge clk); #1;
  endtask
  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h1000_0000 + i;
    idle_all();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_if_valid", {31'b0, bus.if_valid}, 0);
    chk("rst_if_inst", bus.if_inst, 0);
    chk("rst_ld_rvalid", {31'b0, bus.ld_rvalid}, 0);
    chk("rst_ld_rdata", bus.ld_rdata, 0);
    chk("rst_ld_err", {31'b0, bus.ld_err}, 0);
    chk("rst_owner", {30'b0, bus.last_owner}, 0);
    // fetch, then assert reset mid-cycle while the valid is showing
    @(negedge clk); rst_n = 1; bus.if_req = 1; bus.if_addr = 32'h4;
    post();
    chk("pre_rst_valid", {31'b0, bus.if_valid}, 1);
    chk("pre_rst_inst", bus.if_inst, 32'h1000_0001);
    #2 rst_n = 0; #1;
    chk("mid_rst_valid", {31'b0, bus.if_valid}, 0);
    chk("mid_rst_inst", bus.if_inst, 0);
    chk("mid_rst_gnt", {31'b0, bus.if_gnt}, 0);
    chk("mid_rst_memaddr", bus.mem_addr, 0);
    chk("mid_rst_owner", {30'b0, bus.last_owner}, 0);
    @(negedge clk); rst_n = 1; bus.if_addr = 32'h0; #1;
    chk("post_rst_gnt", {31'b0, bus.if_gnt}, 1);
    post();
    chk("post_rst_valid", {31'b0, bus.if_valid}, 1);
    chk("post_rst_inst", bus.if_inst, 32'h1000_0000);
    // fetch stream
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); bus.if_addr = 32'(4 * i); #1;
      chk("fetch_gnt", {31'b0, bus.if_gnt}, 1);
      chk("fetch_memaddr", bus.mem_addr, 32'(4 * i));
      post();
      chk("fetch_valid", {31'b0, bus.if_valid}, 1);
      chk("fetch_inst", bus.if_inst, 32'h1000_0000 + 32'(i));
      chk("fetch_owner", {30'b0, bus.last_owner}, 1);
    end
    // loader write then read
    @(negedge clk); bus.if_req = 0; ld(1, 32'hA0, 32'hDEADBEEF); #1;
    chk("wr_gnt", {31'b0, bus.ld_gnt}, 1);
    chk("wr_we", {31'b0, bus.mem_we}, 1);
    chk("wr_memaddr", bus.mem_addr, 32'hA0);
    post();
    chk("wr_rvalid", {31'b0, bus.ld_rvalid}, 0);
    chk("wr_err", {31'b0, bus.ld_err}, 0);
    chk("wr_ifvalid", {31'b0, bus.if_valid}, 0);
    @(negedge clk); ld(0, 32'hA0, 0); #1;
    chk("rd_we", {31'b0, bus.mem_we}, 0);
    post();
    chk("raw_rvalid", {31'b0, bus.ld_rvalid}, 1);
    chk("raw_rdata", bus.ld_rdata, 32'hDEADBEEF);
    chk("raw_owner", {30'b0, bus.last_owner}, 2);
    @(negedge clk); bus.ld_req = 0;
    post();
    chk("rvalid_pulse", {31'b0, bus.ld_rvalid}, 0);
    // contention: L,L,L,L,F repeating
    @(negedge clk); bus.if_req = 1; bus.if_addr = 32'h10; ld(0, 32'h20, 0);
    for (int k = 0; k < 12; k++) begin
      logic fexp;
      fexp = (k % 5 == 4);
      #1;
      chk("cont_gnt", {30'b0, bus.if_gnt, bus.ld_gnt}, fexp ? 32'd2 : 32'd1);
      chk("cont_memaddr", bus.mem_addr, fexp ? 32'h10 : 32'h20);
      post();
      chk("cont_owner", {30'b0, bus.last_owner}, fexp ? 32'd1 : 32'd2);
      chk("cont_ifvalid", {31'b0, bus.if_valid}, {31'b0, fexp});
      @(negedge clk);
    end
    // errors: misaligned write, out-of-range write, out-of-range fetch
    idle_all(); ld(1, 32'h102, 32'h0BAD0BAD); #1;
    chk("mis_gnt", {31'b0, bus.ld_gnt}, 1);
    chk("mis_we", {31'b0, bus.mem_we}, 0);
    post();
    chk("mis_err", {31'b0, bus.ld_err}, 1);
    @(negedge clk); ld(1, 32'h1000, 32'h0BAD0BAD); #1;
    chk("oor_we", {31'b0, bus.mem_we}, 0);
    post();
    chk("oor_err", {31'b0, bus.ld_err}, 1);
    @(negedge clk); ld(0, 32'h100, 0);
    post();
    chk("unch_err", {31'b0, bus.ld_err}, 0);
    chk("unch_rvalid", {31'b0, bus.ld_rvalid}, 1);
    chk("unch_rdata", bus.ld_rdata, 32'h1000_0040);
    @(negedge clk); ld(0, 32'h1000, 0);
    post();
    chk("oor_rd_err", {31'b0, bus.ld_err}, 1);
    chk("oor_rd_rvalid", {31'b0, bus.ld_rvalid}, 0);
    chk("oor_rd_rdata_held", bus.ld_rdata, 32'h1000_0040);
    @(negedge clk); idle_all(); bus.if_req = 1; bus.if_addr = 32'h1000;
    post();
    chk("oor_fetch_inst", bus.if_inst, 32'h00000013);
    chk("err_pulse_end", {31'b0, bus.ld_err}, 0);
    @(negedge clk); bus.if_addr = 32'hFFE;
    post();
    chk("last_word_inst", bus.if_inst, 32'h1000_03FF);
    // idle
    @(negedge clk); idle_all();
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("idle_we", {31'b0, bus.mem_we}, 0);
      chk("idle_memaddr", bus.mem_addr, 0);
      chk("idle_gnt", {30'b0, bus.if_gnt, bus.ld_gnt}, 0);
      post();
      chk("idle_valids", {29'b0, bus.if_valid, bus.ld_rvalid, bus.ld_err}, 0);
      chk("idle_owner", {30'b0, bus.last_owner}, 0);
      @(negedge clk);
    end
    // burst counter restarts from zero: four loader grants before fetch
    bus.if_req = 1; bus.if_addr = 32'h8; ld(0, 32'h24, 0);
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("reburst_gnt", {30'b0, bus.if_gnt, bus.ld_gnt}, (k == 4) ? 32'd2 : 32'd1);
      @(negedge clk);
    end
    idle_all();
    post();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/imem_arbiter.md
# imem_arbiter

Single-port arbiter and sequencer for the shared instruction memory. It arbitrates between the IF-stage fetch requester and the program-loader/debug requester, drives the memory's address and write controls, and returns registered read data one cycle after each grant. The loader has priority with a bounded burst, so fetch cannot starve during program load. Addresses are byte addresses; the word index is addr[31:2].

## Interface
Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words in the instruction memory; legal word index is 0..DEPTH_WORDS-1.
- BURST_MAX, 4: maximum consecutive loader grants while fetch is waiting.
- NOP_INST, 32'h00000013: instruction returned for an out-of-range fetch (addi x0,x0,0).

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- if_req, input, 1: fetch request.
- if_addr, input, 32: fetch byte address.
- if_gnt, output, 1: combinational; fetch owns the memory port this cycle.
- if_valid, output, 1: registered; if_inst is valid.
- if_inst, output, 32: registered fetch data.
- ld_req, input, 1: loader request.
- ld_we, input, 1: 1 = write, 0 = read.
- ld_addr, input, 32: loader byte address.
- ld_wdata, input, 32: loader write data.
- ld_gnt, output, 1: combinational; loader owns the memory port this cycle.
- ld_rvalid, output, 1: registered; ld_rdata is valid (reads only).
- ld_rdata, output, 32: registered loader read data.
- ld_err, output, 1: registered one-cycle pulse for a rejected loader access.
- mem_addr, output, 32: address to memory (word index = mem_addr[31:2]).
- mem_we, output, 1: memory write enable, sampled at clk rising edge.
- mem_wdata, output, 32: memory write data.
- mem_rdata, input, 32: combinational memory read data for mem_addr.

## Operation
- Grant (combinational, one owner per cycle):
  - Only one requester active: that requester is granted.
  - Both active: loader is granted unless burst_cnt == BURST_MAX, in which case fetch is granted.
  - Neither active: no grant, mem_we = 0, mem_addr = 0.
- Port mux: mem_addr follows the granted requester's address.
- Write gating: mem_we = ld_gnt & ld_we & ~ld_bad, where ld_bad = (ld_addr[1:0] != 0) | (ld_addr[31:2] >= DEPTH_WORDS).
- burst_cnt (saturating, width clog2(BURST_MAX+1)):
  - +1 on a loader grant while if_req = 1.
  - Cleared on a fetch grant, or in any cycle with if_req = 0.
- Fetch out of range (if_addr[31:2] >= DEPTH_WORDS): if_inst = NOP_INST. if_addr[1:0] is ignored.
- Loader error: a loader access with ld_bad is still granted and consumed. No write occurs, ld_rvalid stays 0, and ld_err pulses the next cycle.
- FSM last_owner ∈ {IDLE, FETCH, LOAD}, updated every edge to the current grant. It is for debug visibility only; priority is set by burst_cnt.

## Timing
- Request-to-grant latency: 0 cycles (same cycle).
- Write: commits at the granting edge.
- Read: data captured at the granting edge; if_valid/ld_rvalid high for exactly the following cycle.
- Throughput: one access per cycle. No back-to-back restriction.
- Valids are pulses, not held. A requester keeps req high and advances its address after each gnt.
- Read-after-write at the same address, in consecutive cycles: the read returns the new data.
- Reset (async assert, sync-free release): if_valid = 0, ld_rvalid = 0, ld_err = 0, if_inst = 0, ld_rdata = 0, burst_cnt = 0, last_owner = IDLE.
- Reset mid-access: the pending valid is dropped. A write is committed only if its edge occurred before reset asserted.
- Simultaneous requests with burst_cnt == BURST_MAX: fetch is granted, burst_cnt clears to 0, and the loader is granted the next cycle if both still request.

## Test plan
- Reset: assert rst_n = 0 mid-cycle with if_req = 1 → all outputs 0 immediately; after release, first if_req at addr 0x0 → if_valid the next cycle with if_inst = mem[0].
- Fetch only: if_addr 0x0, 0x4, 0x8 on consecutive cycles → if_gnt = 1 each cycle; if_inst = mem[0], mem[1], mem[2] one cycle later, continuously.
- Loader write then read: write 0xDEADBEEF to 0xA0, then read 0xA0 → ld_rvalid with ld_rdata = 0xDEADBEEF two cycles after the write grant.
- Contention: if_req and ld_req held high for 12 cycles, BURST_MAX = 4 → grant pattern L,L,L,L,F repeating; fetch granted at cycles 5 and 10.
- Errors: loader write to 0x102 → ld_err pulse, memory unchanged. Loader write to 0x1000 (word 1024) → ld_err, no write. Fetch at 0x1000 → if_inst = 0x00000013.
- Idle: no requests → mem_we = 0, no valid pulses, burst_cnt = 0.
